logic_basic_upsizer: RTL and testbench

LOGIC_BASIC_UPSIZER -- requirements
Module: logic_basic_upsizer

---
 rtl/logic_pkg.sv | 10 +
 rtl/logic_basic_upsizer_if.sv | 27 ++
 rtl/logic_basic_upsizer.sv | 107 ++++++++++
 tb/tb_logic_basic_upsizer.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_pkg.sv
// Shared definitions for the logic_* block family: target device selection.
package logic_pkg;

  typedef enum logic [1:0] {
    TARGET_GENERIC = 2'd0,
    TARGET_XILINX  = 2'd1,
    TARGET_INTEL   = 2'd2
  } target_e;

endpackage

// File: rtl/logic_basic_upsizer_if.sv
// Stream bundle for logic_basic_upsizer: narrow rx beats in, packed tx words out.
interface logic_basic_upsizer_if #(
  parameter int WIDTH = 8,
  parameter int RATIO = 4
);

  logic                   rx_tvalid;
  logic [WIDTH-1:0]       rx_tdata;
  logic                   rx_tlast;
  logic                   rx_tready;
  logic                   tx_tvalid;
  logic [WIDTH*RATIO-1:0] tx_tdata;
  logic [RATIO-1:0]       tx_tkeep;
  logic                   tx_tlast;
  logic                   tx_tready;

  modport master (
    output rx_tvalid, rx_tdata, rx_tlast, tx_tready,
    input  rx_tready, tx_tvalid, tx_tdata, tx_tkeep, tx_tlast
  );

  modport slave (
    input  rx_tvalid, rx_tdata, rx_tlast, tx_tready,
    output rx_tready, tx_tvalid, tx_tdata, tx_tkeep, tx_tlast
  );

endinterface

// File: rtl/logic_basic_upsizer.sv
// Packs RATIO narrow rx beats into one wide tx word (lane 0 in the LSBs).
// Define LOGIC_BASIC_UPSIZER_TLAST_EN to close words early on rx_tlast.
module logic_basic_upsizer #(
  parameter int                 WIDTH  = 8,
  parameter int                 RATIO  = 4,
  parameter logic_pkg::target_e TARGET = logic_pkg::TARGET_GENERIC
) (
  input  logic                  aclk,
  input  logic                  areset,
  logic_basic_upsizer_if.slave  bus
);

  localparam int             LW        = $clog2(RATIO);
  localparam logic [LW-1:0]  LAST_LANE = LW'(RATIO - 1);
  localparam logic_pkg::target_e UNUSED_TARGET = TARGET;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_e;

  state_e                 state_q;
  logic [LW-1:0]          lane_q;
  logic [WIDTH*RATIO-1:0] data_q;
  logic [RATIO-1:0]       keep_q;
  logic                   last_q;

  logic                   rx_fire_s;
  logic                   tx_fire_s;
  logic                   beat_last_s;
  logic                   close_s;
  logic [LW-1:0]          slot_s;

`ifdef LOGIC_BASIC_UPSIZER_TLAST_EN
  assign beat_last_s = bus.rx_tlast;
`else
  logic unused_tlast_s;
  assign unused_tlast_s = bus.rx_tlast;
  assign beat_last_s    = 1'b0;
`endif

  // A held word can be replaced in the same cycle it leaves, so ready follows tx_tready in FULL.
  assign bus.rx_tready = (state_q == FILL) || bus.tx_tready;
  assign rx_fire_s     = bus.rx_tvalid && bus.rx_tready;
  assign tx_fire_s     = (state_q == FULL) && bus.tx_tready;
  assign slot_s        = (state_q == FULL) ? {LW{1'b0}} : lane_q;
  assign close_s       = (slot_s == LAST_LANE) || beat_last_s;

  assign bus.tx_tvalid = (state_q == FULL);
  assign bus.tx_tdata  = data_q;
  assign bus.tx_tkeep  = keep_q;
  assign bus.tx_tlast  = last_q;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= FILL;
      lane_q  <= {LW{1'b0}};
      data_q  <= {(WIDTH*RATIO){1'b0}};
      keep_q  <= {RATIO{1'b0}};
      last_q  <= 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          if (rx_fire_s) begin
            data_q[int'(slot_s)*WIDTH +: WIDTH] <= bus.rx_tdata;
            keep_q[slot_s]                      <= 1'b1;
            if (close_s) begin
              state_q <= FULL;
              lane_q  <= {LW{1'b0}};
              last_q  <= beat_last_s;
            end else begin
              lane_q  <= lane_q + LW'(1);
            end
          end
        end
        FULL: begin
          if (tx_fire_s) begin
            if (rx_fire_s) begin
              // Word leaves while the next one starts in lane 0; unused lanes stay zero.
              data_q <= {{(WIDTH*(RATIO-1)){1'b0}}, bus.rx_tdata};
              keep_q <= {{(RATIO-1){1'b0}}, 1'b1};
              last_q <= beat_last_s;
              if (close_s) begin
                state_q <= FULL;
                lane_q  <= {LW{1'b0}};
              end else begin
                state_q <= FILL;
                lane_q  <= LW'(1);
              end
            end else begin
              state_q <= FILL;
              lane_q  <= {LW{1'b0}};
              data_q  <= {(WIDTH*RATIO){1'b0}};
              keep_q  <= {RATIO{1'b0}};
              last_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= FILL;
          lane_q  <= {LW{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_logic_basic_upsizer.sv
// Randomized and directed checks of logic_basic_upsizer against a beat-grouping scoreboard.
module tb_logic_basic_upsizer;

  localparam int W  = 8;
  localparam int R  = 4;
  localparam int DW = W * R;
`ifdef LOGIC_BASIC_UPSIZER_TLAST_EN
  localparam bit TLAST_EN = 1'b1;
`else
  localparam bit TLAST_EN = 1'b0;
`endif

  typedef struct packed {
    logic [DW-1:0] data;
    logic [R-1:0]  keep;
    logic          last;
  } word_t;

  logic aclk = 1'b0;
  logic areset;

  logic_basic_upsizer_if #(.WIDTH(W), .RATIO(R)) bus ();

  logic_basic_upsizer #(
    .WIDTH  (W),
    .RATIO  (R),
    .TARGET (logic_pkg::TARGET_GENERIC)
  ) dut (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus)
  );

  always #5 aclk = ~aclk;

  int vectors     = 0;
  int miscompares = 0;

  word_t      exp_q[$];
  word_t      obs_q[$];
  logic [W-1:0] part_q[$];

  function automatic void sb_clear();
    exp_q.delete();
    obs_q.delete();
    part_q.delete();
  endfunction

  // Reference: accepted beats are grouped into words of R, or fewer when tlast closes one.
  function automatic void model_accept(input logic [W-1:0] d, input logic l);
    word_t w;
    part_q.push_back(d);
    if (part_q.size() == R || (TLAST_EN && l)) begin
      w.data = '0;
      w.keep = '0;
      w.last = TLAST_EN && l;
      for (int k = 0; k < part_q.size(); k++) begin
        w.data[k*W +: W] = part_q[k];
        w.keep[k]        = 1'b1;
      end
      exp_q.push_back(w);
      part_q.delete();
    end
  endfunction

  function automatic word_t cur_word();
    word_t w;
    w.data = bus.tx_tdata;
    w.keep = bus.tx_tkeep;
    w.last = bus.tx_tlast;
    return w;
  endfunction

  // One clock: drive at edge+1, sample handshakes at edge+2, return aligned to next edge+1.
  task automatic tick(input logic rv, input logic [W-1:0] d, input logic rl,
                      input logic tr, output bit rx_hs);
    bus.rx_tvalid = rv;
    bus.rx_tdata  = d;
    bus.rx_tlast  = rl;
    bus.tx_tready = tr;
    #1;
    rx_hs = rv && (bus.rx_tready === 1'b1);
    if (rx_hs) model_accept(d, rl);
    if (bus.tx_tvalid === 1'b1 && tr) obs_q.push_back(cur_word());
    @(posedge aclk);
    #1;
  endtask

  task automatic apply_reset(input int n);
    areset = 1'b1;
    repeat (n) begin
      bus.rx_tvalid = 1'($urandom_range(0, 1));
      bus.rx_tdata  = W'($urandom);
      bus.rx_tlast  = 1'($urandom_range(0, 1));
      bus.tx_tready = 1'($urandom_range(0, 1));
      @(posedge aclk);
      #1;
    end
    sb_clear();
  endtask

  task automatic test_reset();
    apply_reset(3);
    vectors++;
    if (bus.tx_tvalid !== 1'b0) begin
      miscompares++; $display("FAIL reset_tvalid: got %b want 0", bus.tx_tvalid);
    end
    vectors++;
    if (bus.tx_tdata !== 32'h0) begin
      miscompares++; $display("FAIL reset_tdata: got %h want 00000000", bus.tx_tdata);
    end
    vectors++;
    if (bus.tx_tkeep !== 4'h0) begin
      miscompares++; $display("FAIL reset_tkeep: got %h want 0", bus.tx_tkeep);
    end
    vectors++;
    if (bus.tx_tlast !== 1'b0) begin
      miscompares++; $display("FAIL reset_tlast: got %b want 0", bus.tx_tlast);
    end
    areset        = 1'b0;
    bus.rx_tvalid = 1'b0;
    bus.tx_tready = 1'b0;
    #1;
    vectors++;
    if (bus.rx_tready !== 1'b1) begin
      miscompares++; $display("FAIL reset_rx_tready: got %b want 1", bus.rx_tready);
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic test_basic();
    bit hs;
    sb_clear();
    tick(1'b1, 8'h11, 1'b0, 1'b1, hs);
    tick(1'b1, 8'h22, 1'b0, 1'b1, hs);
    tick(1'b1, 8'h33, 1'b0, 1'b1, hs);
    vectors++;
    if (bus.tx_tvalid !== 1'b0) begin
      miscompares++; $display("FAIL basic_early_valid: got %b want 0", bus.tx_tvalid);
    end
    tick(1'b1, 8'h44, 1'b0, 1'b1, hs);
    vectors++;
    if (bus.tx_tvalid !== 1'b1 || bus.tx_tdata !== 32'h44332211 ||
        bus.tx_tkeep !== 4'hF || bus.tx_tlast !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_word: got v=%b d=%h k=%h l=%b want v=1 d=44332211 k=f l=0",
               bus.tx_tvalid, bus.tx_tdata, bus.tx_tkeep, bus.tx_tlast);
    end
    tick(1'b0, 8'h00, 1'b0, 1'b1, hs);
    vectors++;
    if (obs_q.size() != 1 || bus.tx_tvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_drain: got words=%0d v=%b want words=1 v=0", obs_q.size(), bus.tx_tvalid);
    end
  endtask

  task automatic test_stream();
    bit hs;
    int lows = 0;
    sb_clear();
    for (int i = 0; i < 12; i++) begin
      tick(1'b1, W'($urandom), 1'b0, 1'b1, hs);
      if (!hs) lows++;
    end
    tick(1'b0, 8'h00, 1'b0, 1'b1, hs);
    vectors++;
    if (lows != 0) begin
      miscompares++; $display("FAIL stream_ready_low: got %0d stalls want 0", lows);
    end
    vectors++;
    if (obs_q.size() != 3 || exp_q.size() != 3) begin
      miscompares++;
      $display("FAIL stream_count: got %0d words want 3 (model %0d)", obs_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (obs_q[i] !== exp_q[i]) begin
          miscompares++;
          $display("FAIL stream_word%0d: got %h want %h", i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit hs;
    word_t snap;
    sb_clear();
    for (int i = 0; i < 4; i++) tick(1'b1, W'(8'hA0 + i), 1'b0, 1'b0, hs);
    snap = cur_word();
    for (int c = 0; c < 5; c++) begin
      tick(1'b1, 8'h55, 1'b0, 1'b0, hs);
      vectors++;
      if (hs || bus.tx_tvalid !== 1'b1 || cur_word() !== snap) begin
        miscompares++;
        $display("FAIL bp_hold%0d: got acc=%b v=%b w=%h want acc=0 v=1 w=%h",
                 c, hs, bus.tx_tvalid, cur_word(), snap);
      end
    end
    tick(1'b1, 8'h55, 1'b0, 1'b1, hs);
    vectors++;
    if (!hs) begin
      miscompares++; $display("FAIL bp_release_accept: got 0 want 1");
    end
    for (int i = 0; i < 3; i++) tick(1'b1, W'(8'h66 + i), 1'b0, 1'b1, hs);
    tick(1'b0, 8'h00, 1'b0, 1'b1, hs);
    vectors++;
    if (obs_q.size() != 2 || exp_q.size() != 2) begin
      miscompares++;
      $display("FAIL bp_count: got %0d words want 2 (model %0d)", obs_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (obs_q[i] !== exp_q[i]) begin
          miscompares++;
          $display("FAIL bp_word%0d: got %h want %h", i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_tlast();
    bit hs;
    logic [DW-1:0] want_d;
    logic [R-1:0]  want_k;
    logic          want_l;
    sb_clear();
    tick(1'b1, 8'hAA, 1'b0, 1'b1, hs);
    tick(1'b1, 8'hBB, 1'b1, 1'b1, hs);
`ifdef LOGIC_BASIC_UPSIZER_TLAST_EN
    want_d = 32'h0000BBAA;
    want_k = 4'h3;
    want_l = 1'b1;
`else
    tick(1'b1, 8'hCC, 1'b0, 1'b1, hs);
    tick(1'b1, 8'hDD, 1'b0, 1'b1, hs);
    want_d = 32'hDDCCBBAA;
    want_k = 4'hF;
    want_l = 1'b0;
`endif
    vectors++;
    if (bus.tx_tvalid !== 1'b1 || bus.tx_tdata !== want_d ||
        bus.tx_tkeep !== want_k || bus.tx_tlast !== want_l) begin
      miscompares++;
      $display("FAIL tlast_word: got v=%b d=%h k=%h l=%b want v=1 d=%h k=%h l=%b",
               bus.tx_tvalid, bus.tx_tdata, bus.tx_tkeep, bus.tx_tlast, want_d, want_k, want_l);
    end
    tick(1'b0, 8'h00, 1'b0, 1'b1, hs);
  endtask

  task automatic test_reset_mid();
    bit hs;
    sb_clear();
    tick(1'b1, 8'hE1, 1'b0, 1'b1, hs);
    tick(1'b1, 8'hE2, 1'b0, 1'b1, hs);
    apply_reset(1);
    areset = 1'b0;
    for (int i = 1; i <= 4; i++) tick(1'b1, W'(i), 1'b0, 1'b1, hs);
    tick(1'b0, 8'h00, 1'b0, 1'b1, hs);
    vectors++;
    if (obs_q.size() != 1) begin
      miscompares++; $display("FAIL rstmid_count: got %0d words want 1", obs_q.size());
    end else begin
      vectors++;
      if (obs_q[0].data !== 32'h04030201 || obs_q[0].keep !== 4'hF) begin
        miscompares++;
        $display("FAIL rstmid_word: got d=%h k=%h want d=04030201 k=f", obs_q[0].data, obs_q[0].keep);
      end
    end
  endtask

  task automatic test_random();
    bit    hs;
    bit    stall;
    word_t snap;
    int    acc = 0;
    int    cyc = 0;
    int    nerr = 0;
    sb_clear();
    while (acc < 10000 && cyc < 40000) begin
      stall = (bus.tx_tvalid === 1'b1);
      snap  = cur_word();
      begin
        logic rv, tr, rl;
        rv = ($urandom_range(0, 99) < 70);
        tr = ($urandom_range(0, 99) < 70);
        rl = ($urandom_range(0, 4) == 0);
        stall = stall && !tr;
        tick(rv, W'($urandom), rl, tr, hs);
      end
      if (hs) acc++;
      cyc++;
      if (stall) begin
        vectors++;
        if (bus.tx_tvalid !== 1'b1 || cur_word() !== snap) begin
          miscompares++;
          if (nerr++ < 10) $display("FAIL rand_stable: got v=%b w=%h want v=1 w=%h",
                                    bus.tx_tvalid, cur_word(), snap);
        end
      end
    end
    vectors++;
    if (acc < 10000) begin
      miscompares++; $display("FAIL rand_budget: got %0d beats want 10000", acc);
    end
    repeat (3) tick(1'b0, 8'h00, 1'b0, 1'b1, hs);
    vectors++;
    if (obs_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL rand_count: got %0d words want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        if (nerr++ < 10) $display("FAIL rand_word%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    areset        = 1'b1;
    bus.rx_tvalid = 1'b0;
    bus.rx_tdata  = 8'h00;
    bus.rx_tlast  = 1'b0;
    bus.tx_tready = 1'b0;
    test_reset();
    test_basic();
    test_stream();
    test_backpressure();
    test_tlast();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
